// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the read-side drain engine.
// master is the engine's view, slave is the FIFO/downstream view.
interface fifo_rd_stream_if #(
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 16
) ();
  logic                    r_empty;
  logic [MEMORY_WIDTH-1:0] rdata;
  logic                    r_en;
  logic [MEMORY_WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_last;
  logic                    m_ready;
  logic [CNT_WIDTH-1:0]    word_count;

  modport master (
    input  r_empty, rdata, m_ready,
    output r_en, m_data, m_valid, m_last, word_count
  );

  modport slave (
    output r_empty, rdata, m_ready,
    input  r_en, m_data, m_valid, m_last, word_count
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops a FWFT FIFO into a registered valid/ready stream
// with a one-word skid slot, burst framing on m_last and an accepted-word counter.
module fifo_rd_stream #(
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned BURST_LEN    = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  fifo_rd_stream_if.master      bus
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    pop_c;
  logic                    accept_c;
  logic                    load_out_c;
  logic                    load_skid_c;
  logic                    skid_to_out_c;
  logic                    pop_last_c;
  logic [MEMORY_WIDTH-1:0] out_data;
  logic                    out_last;
  logic                    out_valid;
  logic [MEMORY_WIDTH-1:0] skid_data;
  logic                    skid_last;
  logic [BEAT_W-1:0]       beat;
  logic [CNT_WIDTH-1:0]    word_cnt;

  // Occupancy state register
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (pop_c) state_nxt = ONE;
      ONE: begin
        if (pop_c && !accept_c)      state_nxt = TWO;
        else if (!pop_c && accept_c) state_nxt = EMPTY;
      end
      TWO:     if (accept_c) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake decode and datapath load enables; pop never looks at m_ready
  always_comb begin
    pop_c         = !bus.r_empty && (state != TWO) && !rrst;
    accept_c      = (state != EMPTY) && bus.m_ready;
    pop_last_c    = (beat == BEAT_MAX);
    load_out_c    = 1'b0;
    load_skid_c   = 1'b0;
    skid_to_out_c = 1'b0;
    case (state)
      EMPTY: load_out_c = pop_c;
      ONE: begin
        load_out_c  = pop_c && accept_c;
        load_skid_c = pop_c && !accept_c;
      end
      TWO:     skid_to_out_c = accept_c;
      default: ;
    endcase
  end

  // Output register, skid slot and valid flag
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      out_valid <= (state_nxt != EMPTY);
      if (load_out_c) begin
        out_data <= bus.rdata;
        out_last <= pop_last_c;
      end else if (skid_to_out_c) begin
        out_data <= skid_data;
        out_last <= skid_last;
      end
      if (load_skid_c) begin
        skid_data <= bus.rdata;
        skid_last <= pop_last_c;
      end
    end
  end

  // Burst beat tracks pops, so the last flag is bound to the word at pop time
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      beat     <= '0;
      word_cnt <= '0;
    end else begin
      if (pop_c) beat <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
      if (accept_c) word_cnt <= word_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.r_en       = pop_c;
  assign bus.m_data     = out_data;
  assign bus.m_last     = out_last;
  assign bus.m_valid    = out_valid;
  assign bus.word_count = word_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: FIFO model feeds the DUT, expected words are
// queued at load time and a monitor checks every accepted transfer.
module tb_fifo_rd_stream;
  localparam int unsigned W = 8;

  logic r_clk = 1'b0;
  logic rrst;
  logic rst2;
  always #5 r_clk = ~r_clk;

  fifo_rd_stream_if #(.MEMORY_WIDTH(W), .CNT_WIDTH(16)) bus ();
  fifo_rd_stream_if #(.MEMORY_WIDTH(W), .CNT_WIDTH(4))  bus2 ();

  fifo_rd_stream #(.MEMORY_WIDTH(W), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
    .r_clk(r_clk), .rrst(rrst), .bus(bus));

  // Second instance covers BURST_LEN=1 and a narrow counter wrap
  fifo_rd_stream #(.MEMORY_WIDTH(W), .BURST_LEN(1), .CNT_WIDTH(4)) dut2 (
    .r_clk(r_clk), .rrst(rst2), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] fifo2_q[$];
  logic [W:0]   exp_q[$];
  logic [W:0]   exp2_q[$];
  int   push_idx   = 0;
  int   pop_cnt    = 0;
  int   ready_mode = 1;
  bit   gap_en     = 0;
  bit   gap;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic prev_last;
  logic [W:0] mon_e;
  logic [W:0] mon2_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    logic l;
    l = ((push_idx % 4) == 3);
    fifo_q.push_back(d);
    exp_q.push_back({l, d});
    push_idx++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      @(posedge r_clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge r_clk);
    @(negedge r_clk);
  endtask

  // FIFO model for the main DUT: pop on r_en, then present head and drive m_ready
  always @(posedge r_clk) begin
    if (bus.r_en) begin
      check("pop_not_empty", 32'(bus.r_empty), 32'd0);
      if (fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
    end
    #2;
    gap = gap_en && ($urandom_range(0, 2) == 0);
    bus.r_empty = gap || (fifo_q.size() == 0);
    bus.rdata   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // FIFO model for the second DUT, always ready downstream
  always @(posedge r_clk) begin
    if (bus2.r_en && fifo2_q.size() != 0) void'(fifo2_q.pop_front());
    #2;
    bus2.r_empty = (fifo2_q.size() == 0);
    bus2.rdata   = (fifo2_q.size() != 0) ? fifo2_q[0] : '0;
  end

  // Monitor: compare each accepted word and enforce stability while stalled
  always @(negedge r_clk) begin
    if (rrst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
        check("stall_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_qsize", 32'd0, 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_data", 32'(bus.m_data), 32'(mon_e[W-1:0]));
          check("stream_last", 32'(bus.m_last), 32'(mon_e[W]));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  always @(negedge r_clk) begin
    if (!rst2 && bus2.m_valid && bus2.m_ready && exp2_q.size() != 0) begin
      mon2_e = exp2_q.pop_front();
      check("b1_data", 32'(bus2.m_data), 32'(mon2_e[W-1:0]));
      check("b1_last", 32'(bus2.m_last), 32'(mon2_e[W]));
    end
  end

  initial begin
    int p0;
    rrst = 1'b1;
    rst2 = 1'b1;
    bus.r_empty  = 1'b1;
    bus.rdata    = '0;
    bus.m_ready  = 1'b0;
    bus2.r_empty = 1'b1;
    bus2.rdata   = '0;
    bus2.m_ready = 1'b1;
    tick(3);

    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    check("rst_last", 32'(bus.m_last), 32'd0);
    check("rst_count", 32'(bus.word_count), 32'd0);
    check("rst_ren", 32'(bus.r_en), 32'd0);
    rrst = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      fifo2_q.push_back(W'(8'h50 + i));
      exp2_q.push_back({1'b1, W'(8'h50 + i)});
    end
    tick(1);

    // Streaming 0x01..0x08 at full rate
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    repeat (8) @(posedge r_clk);
    @(negedge r_clk);
    check("stream_count_7", 32'(bus.word_count), 32'd7);
    check("stream_valid_tail", 32'(bus.m_valid), 32'd1);
    @(posedge r_clk);
    @(negedge r_clk);
    check("stream_count_8", 32'(bus.word_count), 32'd8);
    check("stream_idle", 32'(bus.m_valid), 32'd0);
    tick(1);

    // Back-pressure: three words, ready low for five cycles
    ready_mode = 0;
    tick(1);
    p0 = pop_cnt;
    push_word(8'h10);
    push_word(8'h11);
    push_word(8'h12);
    repeat (5) @(posedge r_clk);
    @(negedge r_clk);
    check("bp_pops", 32'(pop_cnt - p0), 32'd2);
    check("bp_ren", 32'(bus.r_en), 32'd0);
    check("bp_valid", 32'(bus.m_valid), 32'd1);
    check("bp_data", 32'(bus.m_data), 32'h10);
    ready_mode = 1;
    wait_drain("bp", 100);
    check("bp_count", 32'(bus.word_count), 32'd11);
    tick(1);

    // Reset while holding two words with three left in the FIFO
    ready_mode = 0;
    for (int i = 0; i < 5; i++) push_word(W'(8'h30 + i));
    tick(4);
    rrst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_data", 32'(bus.m_data), 32'd0);
    check("mid_rst_last", 32'(bus.m_last), 32'd0);
    check("mid_rst_count", 32'(bus.word_count), 32'd0);
    check("mid_rst_ren", 32'(bus.r_en), 32'd0);
    check("mid_rst_fifo_left", 32'(fifo_q.size()), 32'd3);
    exp_q.delete();
    push_idx = 0;
    @(negedge r_clk);
    check("rst_hold_ren", 32'(bus.r_en), 32'd0);
    tick(1);
    fifo_q.delete();
    tick(1);
    rrst = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) push_word(W'(8'h40 + i));
    wait_drain("post_rst", 100);
    check("post_rst_count", 32'(bus.word_count), 32'd8);
    tick(1);

    // Random ready and FIFO underflow gaps over 1000 words
    rrst = 1'b1;
    tick(1);
    rrst = 1'b0;
    push_idx   = 0;
    gap_en     = 1;
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) push_word(W'($urandom_range(0, 255)));
    wait_drain("rand", 20000);
    check("rand_count", 32'(bus.word_count), 32'd1000);
    gap_en = 0;

    check("b1_drained", 32'(exp2_q.size()), 32'd0);
    check("b1_count_wrap", 32'(bus2.word_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the asynchronous FIFO, living entirely in the read clock domain. It pops words from the FIFO read port and presents them on a valid/ready stream with a registered output stage and a one-word skid slot, so back-pressure never loses or duplicates data. Words are framed into fixed-length bursts via `m_last`, and accepted transfers are counted.

## Interface

Parameters:
- `MEMORY_WIDTH`, default 8: data word width, matching the FIFO `rdata` width.
- `BURST_LEN`, default 4: words per burst, must be ≥1; `m_last` marks every `BURST_LEN`-th word.
- `CNT_WIDTH`, default 16: width of `word_count`.

Ports:
- `r_clk` in 1: read clock, the only clock. All state updates on its rising edge.
- `rrst` in 1: reset, asynchronous, active-high.
- `r_empty` in 1: FIFO empty flag.
- `rdata` in `MEMORY_WIDTH`: FIFO read data, first-word-fall-through (valid whenever `r_empty`=0).
- `r_en` out 1: FIFO pop request, combinational.
- `m_data` out `MEMORY_WIDTH`: stream data, registered.
- `m_valid` out 1: stream valid, registered.
- `m_last` out 1: last word of burst, registered, qualified by `m_valid`.
- `m_ready` in 1: downstream ready.
- `word_count` out `CNT_WIDTH`: number of accepted stream transfers, modulo 2^`CNT_WIDTH`.

## Operation

- **Storage:** output register (`m_data`/`m_last`) plus a skid register (data + last flag).
- **State machine** (occupancy):
  - **EMPTY:** nothing held.
  - **ONE:** output register valid, skid empty.
  - **TWO:** output and skid both valid.
- **Derived signals:**
  - `m_valid` = (state != EMPTY).
  - pop = `r_en` = !`r_empty` && (state != TWO) && !`rrst`.
  - accept = `m_valid` && `m_ready`.
- **Transitions:**
  - EMPTY: pop → ONE (output reg ← `rdata`); else stay.
  - ONE:
    - pop && accept → ONE (output reg ← `rdata`).
    - pop && !accept → TWO (skid ← `rdata`).
    - !pop && accept → EMPTY.
    - otherwise hold.
  - TWO: accept → ONE (output reg ← skid); else hold. No pop in TWO.
- **No combinational path from `m_ready` to `r_en`.** `r_en` depends only on state and `r_empty`.
- **Burst framing:**
  - Beat counter `ceil(log2(BURST_LEN))` bits (min 1), incremented on every pop.
  - Wraps to 0 after value `BURST_LEN`-1.
  - The popped word's last flag = (beat == `BURST_LEN`-1); the flag travels with the word through skid/output.
  - With `BURST_LEN`=1, every word is last.
- **`word_count`:** +1 on every accept; wraps from 2^`CNT_WIDTH`-1 to 0.
- **Ordering:** words leave in exact pop order; no drops, no duplicates.
- **Idle data:** `m_data`/`m_last` hold their last value when `m_valid`=0 and are don't-care to downstream.

## Timing

- **Reset** (`rrst` high, async):
  - state EMPTY; `m_valid`=0, `m_data`=0, `m_last`=0.
  - skid cleared, beat counter 0, `word_count`=0.
  - `r_en`=0 for as long as `rrst` is high.
- **Reset mid-operation:** up to two held words are discarded. They are not returned to the FIFO; FIFO/system reset is coordinated externally.
- **Latency:** `r_empty` falls in cycle N with state EMPTY → pop in cycle N → `m_valid`=1 with that word in cycle N+1.
- **Throughput:** with `m_ready` held at 1 and FIFO non-empty, one word per cycle sustained.
- **Back-pressure:**
  - `m_ready`=0 while the FIFO is non-empty: at most one further pop (into skid), then `r_en`=0.
  - On the first `m_ready`=1 cycle in TWO, the skid word moves to output next cycle, and `r_en` may reassert in that following cycle.
- **Handshake rule:** once `m_valid`=1, `m_data`/`m_last` stay stable until accept.
- **FIFO empties while stalled:** state holds, `m_valid` stays 1.

## Test plan

- **Reset values:** assert `rrst` mid-cycle with FIFO holding 3 words and state TWO → `m_valid`=0, `m_last`=0, `m_data`=0, `word_count`=0, `r_en`=0 immediately; after release, first word out has beat 0.
- **Streaming:** FIFO preloaded 0x01..0x08, `BURST_LEN`=4, `m_ready`=1 → `m_data` 0x01..0x08 on consecutive cycles starting one cycle after the first pop; `m_last`=1 only on 0x04 and 0x08; `word_count`=8.
- **Back-pressure:** 0x10,0x11,0x12 queued, `m_ready`=0 for 5 cycles → exactly 2 pops, `m_data`=0x10 stable, `r_en`=0 in TWO. Then `m_ready`=1 → 0x10, 0x11, 0x12 in order, no loss or duplicates.
- **Random ready with FIFO underflow gaps:** 1000 words, random `m_ready`/`r_empty` → output sequence equals input sequence, `m_last` every 4th word, `word_count`=1000.
- **Wrap cases:** `CNT_WIDTH`=4, 17 transfers → `word_count`=1. `BURST_LEN`=1 → `m_last`=1 on every word.
